voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic note-event front end that drives the four tone channels of the audio codec (chN_en / chN_f).
- Accepts note-on/note-off events from the keyboard/sequencer over a valid/ready handshake.
- Assigns each note to one of 4 voices, converts the MIDI note number to a phase increment, and steals the least-recently-allocated voice when all are busy.
- Runs in the codec clock domain, so its outputs connect directly to the codec with no synchronisers.

Parameters:
- MIN_NOTE, 36, lowest accepted MIDI note (C2).
- MAX_NOTE, 96, highest accepted MIDI note (C7).

Ports:
- iCLK_18_4 in 1: 18.432 MHz codec clock.
- iRST_N in 1: reset. One clock; reset is asynchronous and active-low.
- iEVT_VALID in 1: event present.
- oEVT_READY out 1: allocator can accept an event.
- iEVT_ON in 1: 1 = note-on, 0 = note-off.
- iEVT_NOTE in 7: MIDI note number.
- iALL_OFF in 1: single-cycle panic; silences everything.
- ch1_en..ch4_en out 1 each: voice enable to the codec.
- ch1_f..ch4_f out 16 each: phase increment to the codec.
- oDROP_CNT out 8: saturating count of rejected out-of-range events.

Behaviour:
- Reset values:
  - all chN_en = 0, chN_f = 0, oDROP_CNT = 0.
  - oEVT_READY = 1 (state IDLE).
  - voice notes cleared; LRU ranks ch1..ch4 = 0,1,2,3 (3 = oldest).
- Handshake:
  - An event is accepted on a rising edge with iEVT_VALID & oEVT_READY.
  - Note and on/off are captured at that edge.
  - oEVT_READY is high only in IDLE.
  - iEVT_* are ignored outside acceptance.
- FSM: IDLE -> SEARCH -> LOOKUP -> COMMIT -> (REARM) -> IDLE.
  - SEARCH:
    - range check (note outside MIN_NOTE..MAX_NOTE: oDROP_CNT += 1, saturating at 255; return to IDLE, no output change).
    - register the hit voice (enabled voice holding this note, lowest index).
    - register the first free voice (lowest index with en = 0).
    - register the victim (rank 3).
  - LOOKUP: registered ROM read of the increment.
  - COMMIT, note-on:
    - target = hit, else free, else victim.
    - free target: chN_f <= inc, chN_en <= 1 on the same edge, then IDLE.
    - hit or victim target: chN_f <= inc, chN_en <= 0, go to REARM.
    - REARM sets chN_en <= 1. This gives exactly one clock with en low, which restarts the codec ramp.
    - Rank update: voices with rank < target rank increment; target rank = 0.
  - COMMIT, note-off: hit voice en <= 0 (chN_f holds its value); no hit: no change. Ranks unchanged.
- Latency:
  - Free-voice note-on or note-off: outputs change on the 3rd rising edge after acceptance; ready returns on that edge.
  - Retrigger/steal: en falls on the 3rd edge and rises on the 4th; ready returns on the 4th.
- Increment: inc = round(1.25 * 440 * 2^((n-69)/12)).
  - Codec output frequency = 0.8 * inc at 48 kHz LRCK with a 60000 ramp wrap.
  - Range 82 (note 36) .. 2616 (note 96); always fits in 16 bits.
- iALL_OFF:
  - Highest priority in any state.
  - Next edge: all en = 0, notes cleared, ranks reset to 0,1,2,3, FSM to IDLE.
  - Any in-flight event is aborted.
  - oEVT_READY is low in the iALL_OFF cycle, so a coincident event is not accepted.
  - chN_f and oDROP_CNT are held.
- Repeated note-on of an already-sounding note retriggers the same voice; the note never occupies two voices.
- Reset asserted mid-operation: immediate return to reset values.

Decomposition:
- Package voice_alloc_pkg: state enum, NUM_VOICES = 4, default MIN_NOTE/MAX_NOTE, increment width (16), LRU rank width (2).
- One sub-module, note_inc_rom:
  - synchronous 61-entry ROM, note offset -> 16-bit increment.
  - contents generated from the formula above.

Test Plan:
- Reset, then on 69 -> ch1_en = 1, ch1_f = 550 on the 3rd edge after acceptance; others 0; ready high again.
- On 60, 64, 67, 69 in sequence -> ch1..ch4 f = 327, 412, 490, 550, all en = 1.
- Then on 72 -> ch1 stolen: ch1_en low exactly 1 cycle, then high with ch1_f = 654.
- With that state, off 64 -> ch2_en = 0 and ch2_f stays 412; off 50 (not sounding) -> no change.
- On 69 while sounding on ch4 -> ch4 retriggered (1-cycle en low, f = 550); no second voice used.
- On 30 and on 100 -> no output change; oDROP_CNT = 2. Then 300 bad events -> oDROP_CNT = 255.
- iALL_OFF asserted in LOOKUP of an on 60 event, with iEVT_VALID held -> all en = 0, no allocation, event accepted only in a later cycle; next on 60 lands on ch1.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// Shared types and sizing for the four-voice note allocator.
package voice_alloc_pkg;

  localparam int unsigned NUM_VOICES    = 4;
  localparam int unsigned NOTE_W        = 7;
  localparam int unsigned INC_W         = 16;
  localparam int unsigned RANK_W        = 2;
  localparam int unsigned VIDX_W        = 2;
  localparam int unsigned DROP_W        = 8;
  localparam int unsigned DEF_MIN_NOTE  = 36;
  localparam int unsigned DEF_MAX_NOTE  = 96;
  localparam int unsigned ROM_BASE_NOTE = 36;
  localparam int unsigned ROM_DEPTH     = 61;
  localparam int unsigned ROM_AW        = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOOKUP,
    ST_COMMIT,
    ST_REARM
  } state_e;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
  } evt_t;

endpackage

// File: rtl/note_inc_rom.sv
// Synchronous note -> phase increment ROM, round(550 * 2^((n-69)/12)) for notes 36..96.
module note_inc_rom
  import voice_alloc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd,
  input  logic [ROM_AW-1:0] i_addr,
  output logic [INC_W-1:0]  o_inc
);

  localparam logic [INC_W-1:0] INC_TABLE [ROM_DEPTH] = '{
    16'd82,   16'd87,   16'd92,   16'd97,   16'd103,  16'd109,  16'd116,  16'd122,  16'd130,
    16'd138,  16'd146,  16'd154,  16'd164,  16'd173,  16'd184,
    16'd194,  16'd206,  16'd218,  16'd231,  16'd245,  16'd260,
    16'd275,  16'd291,  16'd309,  16'd327,  16'd346,  16'd367,
    16'd389,  16'd412,  16'd437,  16'd462,  16'd490,  16'd519,
    16'd550,  16'd583,  16'd617,  16'd654,  16'd693,  16'd734,
    16'd778,  16'd824,  16'd873,  16'd925,  16'd980,  16'd1038,
    16'd1100, 16'd1165, 16'd1235, 16'd1308, 16'd1386, 16'd1468,
    16'd1556, 16'd1648, 16'd1746, 16'd1850, 16'd1960, 16'd2077,
    16'd2200, 16'd2331, 16'd2469, 16'd2616
  };

  logic [INC_W-1:0] w_inc;
  logic [INC_W-1:0] r_inc;

  always_comb begin
    w_inc = '0;
    if (i_addr < ROM_AW'(ROM_DEPTH)) w_inc = INC_TABLE[i_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_inc <= '0;
    else if (i_rd) r_inc <= w_inc;
  end

  assign o_inc = r_inc;

endmodule

// File: rtl/voice_allocator.sv
// Four-voice note allocator: handshake intake, hit/free/LRU voice choice, increment lookup,
// and codec channel drive with a one-clock enable drop on retrigger or steal.
module voice_allocator #(
  parameter int unsigned MIN_NOTE = voice_alloc_pkg::DEF_MIN_NOTE,
  parameter int unsigned MAX_NOTE = voice_alloc_pkg::DEF_MAX_NOTE
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic        iEVT_VALID,
  output logic        oEVT_READY,
  input  logic        iEVT_ON,
  input  logic [6:0]  iEVT_NOTE,
  input  logic        iALL_OFF,
  output logic        ch1_en,
  output logic        ch2_en,
  output logic        ch3_en,
  output logic        ch4_en,
  output logic [15:0] ch1_f,
  output logic [15:0] ch2_f,
  output logic [15:0] ch3_f,
  output logic [15:0] ch4_f,
  output logic [7:0]  oDROP_CNT
);
  import voice_alloc_pkg::*;

  state_e                r_state;
  state_e                w_state_nxt;
  evt_t                  r_evt;
  logic [NUM_VOICES-1:0] r_en;
  logic [INC_W-1:0]      r_f     [NUM_VOICES];
  logic [NOTE_W-1:0]     r_vnote [NUM_VOICES];
  logic [RANK_W-1:0]     r_rank  [NUM_VOICES];
  logic [DROP_W-1:0]     r_drop;
  logic                  r_hit_vld;
  logic                  r_free_vld;
  logic [VIDX_W-1:0]     r_hit_idx;
  logic [VIDX_W-1:0]     r_free_idx;
  logic [VIDX_W-1:0]     r_victim_idx;
  logic [VIDX_W-1:0]     r_tgt_idx;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_hit_vld;
  logic                  w_free_vld;
  logic [VIDX_W-1:0]     w_hit_idx;
  logic [VIDX_W-1:0]     w_free_idx;
  logic [VIDX_W-1:0]     w_victim_idx;
  logic [VIDX_W-1:0]     w_tgt_idx;
  logic                  w_tgt_free;
  logic                  w_rom_rd;
  logic [ROM_AW-1:0]     w_rom_addr;
  logic [INC_W-1:0]      w_inc;

  assign oEVT_READY = (r_state == ST_IDLE) && !iALL_OFF;
  assign w_accept   = iEVT_VALID && oEVT_READY;
  assign w_in_range = (r_evt.note >= NOTE_W'(MIN_NOTE)) && (r_evt.note <= NOTE_W'(MAX_NOTE));
  assign w_rom_rd   = (r_state == ST_LOOKUP);
  assign w_rom_addr = ROM_AW'(r_evt.note - NOTE_W'(ROM_BASE_NOTE));

  note_inc_rom u_rom (
    .i_clk   (iCLK_18_4),
    .i_rst_n (iRST_N),
    .i_rd    (w_rom_rd),
    .i_addr  (w_rom_addr),
    .o_inc   (w_inc)
  );

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_hit_vld    = 1'b0;
    w_hit_idx    = '0;
    w_free_vld   = 1'b0;
    w_free_idx   = '0;
    w_victim_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_en[i] && (r_vnote[i] == r_evt.note)) begin
        w_hit_vld = 1'b1;
        w_hit_idx = VIDX_W'(i);
      end
      if (!r_en[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = VIDX_W'(i);
      end
      if (r_rank[i] == RANK_W'(NUM_VOICES - 1)) w_victim_idx = VIDX_W'(i);
    end
  end

  always_comb begin
    w_tgt_idx  = r_victim_idx;
    w_tgt_free = 1'b0;
    if (r_hit_vld) begin
      w_tgt_idx = r_hit_idx;
    end else if (r_free_vld) begin
      w_tgt_idx  = r_free_idx;
      w_tgt_free = 1'b1;
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (iALL_OFF) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_accept) w_state_nxt = ST_SEARCH;
        ST_SEARCH: w_state_nxt = w_in_range ? ST_LOOKUP : ST_IDLE;
        ST_LOOKUP: w_state_nxt = ST_COMMIT;
        ST_COMMIT: w_state_nxt = (r_evt.on && !w_tgt_free) ? ST_REARM : ST_IDLE;
        ST_REARM:  w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Voice table, LRU ranks and drop counter; panic clears voices but keeps increments and drops.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_evt        <= '0;
      r_en         <= '0;
      r_drop       <= '0;
      r_hit_vld    <= 1'b0;
      r_free_vld   <= 1'b0;
      r_hit_idx    <= '0;
      r_free_idx   <= '0;
      r_victim_idx <= '0;
      r_tgt_idx    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_f[i]     <= '0;
        r_vnote[i] <= '0;
        r_rank[i]  <= RANK_W'(i);
      end
    end else if (iALL_OFF) begin
      r_en <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vnote[i] <= '0;
        r_rank[i]  <= RANK_W'(i);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_evt <= '{on: iEVT_ON, note: iEVT_NOTE};
        end
        ST_SEARCH: begin
          if (!w_in_range && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
          r_hit_vld    <= w_hit_vld;
          r_hit_idx    <= w_hit_idx;
          r_free_vld   <= w_free_vld;
          r_free_idx   <= w_free_idx;
          r_victim_idx <= w_victim_idx;
        end
        ST_COMMIT: begin
          if (r_evt.on) begin
            r_f[w_tgt_idx]     <= w_inc;
            r_en[w_tgt_idx]    <= w_tgt_free;
            r_vnote[w_tgt_idx] <= r_evt.note;
            r_tgt_idx          <= w_tgt_idx;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (VIDX_W'(i) == w_tgt_idx)          r_rank[i] <= '0;
              else if (r_rank[i] < r_rank[w_tgt_idx]) r_rank[i] <= r_rank[i] + RANK_W'(1);
            end
          end else if (r_hit_vld) begin
            r_en[r_hit_idx] <= 1'b0;
          end
        end
        ST_REARM: begin
          r_en[r_tgt_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ch1_en    = r_en[0];
  assign ch2_en    = r_en[1];
  assign ch3_en    = r_en[2];
  assign ch4_en    = r_en[3];
  assign ch1_f     = r_f[0];
  assign ch2_f     = r_f[1];
  assign ch3_f     = r_f[2];
  assign ch4_f     = r_f[3];
  assign oDROP_CNT = r_drop;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a queue/array reference model predicts each event's outcome.
module tb_voice_allocator;

  typedef struct packed {
    logic [3:0]       en;
    logic [3:0][15:0] f;
    logic [7:0]       drop;
  } snap_t;

  typedef struct packed {
    int    lat;
    snap_t mid;
    snap_t fin;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_valid = 1'b0;
  logic        evt_ready;
  logic        evt_on = 1'b0;
  logic [6:0]  evt_note = '0;
  logic        all_off = 1'b0;
  logic        ch1_en, ch2_en, ch3_en, ch4_en;
  logic [15:0] ch1_f, ch2_f, ch3_f, ch4_f;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb_q[$];

  logic [3:0]       m_en;
  logic [3:0][15:0] m_f;
  int               m_note [4];
  int               lru[$];
  int               m_drop;

  voice_allocator dut (
    .iCLK_18_4  (clk),
    .iRST_N     (rst_n),
    .iEVT_VALID (evt_valid),
    .oEVT_READY (evt_ready),
    .iEVT_ON    (evt_on),
    .iEVT_NOTE  (evt_note),
    .iALL_OFF   (all_off),
    .ch1_en     (ch1_en),
    .ch2_en     (ch2_en),
    .ch3_en     (ch3_en),
    .ch4_en     (ch4_en),
    .ch1_f      (ch1_f),
    .ch2_f      (ch2_f),
    .ch3_f      (ch3_f),
    .ch4_f      (ch4_f),
    .oDROP_CNT  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic snap_t get_snap();
    snap_t s;
    s.en   = {ch4_en, ch3_en, ch2_en, ch1_en};
    s.f    = {ch4_f, ch3_f, ch2_f, ch1_f};
    s.drop = drop_cnt;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.en   = m_en;
    s.f    = m_f;
    s.drop = 8'(m_drop);
    return s;
  endfunction

  function automatic logic [15:0] inc_of(int n);
    real x;
    x = 1.25 * 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    return 16'($rtoi(x + 0.5));
  endfunction

  function automatic void model_all_off();
    m_en = '0;
    for (int i = 0; i < 4; i++) m_note[i] = -1;
    lru = {0, 1, 2, 3};
  endfunction

  // Predicts latency, the state seen the cycle before ready returns, and the final state.
  function automatic exp_t model_event(bit on, int n);
    exp_t e;
    int   hit, free_v, t;
    e.mid = model_snap();
    if (n < 36 || n > 96) begin
      if (m_drop < 255) m_drop++;
      e.lat = 2;
      e.fin = model_snap();
      return e;
    end
    hit = -1;
    free_v = -1;
    for (int i = 3; i >= 0; i--) begin
      if (m_en[i] && m_note[i] == n) hit = i;
      if (!m_en[i]) free_v = i;
    end
    e.lat = 4;
    if (!on) begin
      if (hit >= 0) m_en[hit] = 1'b0;
      e.fin = model_snap();
      return e;
    end
    t = (hit >= 0) ? hit : (free_v >= 0) ? free_v : lru[3];
    m_f[t]    = inc_of(n);
    m_note[t] = n;
    for (int k = 0; k < lru.size(); k++) begin
      if (lru[k] == t) begin
        lru.delete(k);
        break;
      end
    end
    lru.push_front(t);
    if (hit < 0 && free_v >= 0) begin
      m_en[t] = 1'b1;
    end else begin
      m_en[t] = 1'b0;
      e.mid   = model_snap();
      m_en[t] = 1'b1;
      e.lat   = 5;
    end
    e.fin = model_snap();
    return e;
  endfunction

  task automatic chk_snap(input string nm, input snap_t act, input snap_t want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got en=%b f=%h drop=%0d, expected en=%b f=%h drop=%0d",
                  nm, act.en, act.f, act.drop, want.en, want.f, want.drop);
  endtask

  task automatic chk_val(input string nm, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (evt_ready) ok = 1'b1;
    end
    if (!ok) chk_val("idle_timeout", 0, 1);
  endtask

  task automatic wait_accept();
    bit acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (evt_ready) acc = 1'b1;
    end
    if (!acc) chk_val("accept_timeout", 0, 1);
    @(posedge clk);
    #1 evt_valid = 1'b0;
  endtask

  task automatic send(input bit on, input int n);
    sb_q.push_back(model_event(on, n));
    @(posedge clk);
    #1;
    evt_on    = on;
    evt_note  = 7'(n);
    evt_valid = 1'b1;
    wait_accept();
    wait_idle();
  endtask

  // Panic in IDLE with a coincident event that must not be taken.
  task automatic panic_idle();
    @(posedge clk);
    #1;
    all_off   = 1'b1;
    evt_valid = 1'b1;
    evt_on    = 1'b1;
    evt_note  = 7'd60;
    @(negedge clk);
    chk_val("ready_during_all_off", int'(evt_ready), 0);
    @(posedge clk);
    #1;
    all_off   = 1'b0;
    evt_valid = 1'b0;
    model_all_off();
    @(negedge clk);
    chk_snap("after_all_off", get_snap(), model_snap());
    chk_val("ready_after_all_off", int'(evt_ready), 1);
  endtask

  // Scoreboard monitor: each observed acceptance pops one prediction.
  initial begin : monitor
    exp_t  e;
    snap_t mid;
    int    cyc;
    bit    skip;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (rst_n && evt_valid && evt_ready) begin
        if (sb_q.size() == 0) begin
          chk_val("unexpected_accept", 1, 0);
        end else begin
          e   = sb_q.pop_front();
          cyc = 0;
          mid = '0;
          do begin
            @(negedge clk);
            cyc++;
            if (cyc == e.lat - 1) mid = get_snap();
          end while (!evt_ready && cyc < 20);
          chk_val("latency", cyc, e.lat);
          chk_snap("pre_ready_state", mid, e.mid);
          chk_snap("final_state", get_snap(), e.fin);
          skip = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t a;
    int   r, n, v;
    m_f    = '0;
    m_drop = 0;
    model_all_off();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_snap("reset_state", get_snap(), model_snap());
    chk_val("reset_ready", int'(evt_ready), 1);

    send(1'b1, 69);
    chk_val("ch1_f_note69", int'(ch1_f), 550);
    chk_val("ch1_en_note69", int'(ch1_en), 1);

    panic_idle();
    send(1'b1, 60);
    send(1'b1, 64);
    send(1'b1, 67);
    send(1'b1, 69);
    send(1'b1, 72);
    chk_val("steal_ch1_f", int'(ch1_f), 654);
    send(1'b0, 64);
    chk_val("off_keeps_ch2_f", int'(ch2_f), 412);
    send(1'b0, 50);
    send(1'b1, 69);
    send(1'b1, 30);
    send(1'b1, 100);
    chk_val("drop_after_two", int'(drop_cnt), 2);
    for (int i = 0; i < 300; i++) begin
      n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 35)) : int'($urandom_range(97, 127));
      send(1'($urandom_range(0, 1)), n);
    end
    chk_val("drop_saturated", int'(drop_cnt), 255);

    // Panic during LOOKUP with the event still offered: abort, then a fresh acceptance.
    a.lat = 3;
    a.mid = model_snap();
    model_all_off();
    a.fin = model_snap();
    sb_q.push_back(a);
    sb_q.push_back(model_event(1'b1, 60));
    @(posedge clk);
    #1;
    evt_on    = 1'b1;
    evt_note  = 7'd60;
    evt_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 all_off = 1'b1;
    @(negedge clk);
    chk_val("ready_low_in_lookup", int'(evt_ready), 0);
    @(posedge clk);
    #1 all_off = 1'b0;
    wait_accept();
    wait_idle();
    chk_val("abort_retry_ch1_f", int'(ch1_f), 327);
    chk_val("abort_retry_en", int'({ch4_en, ch3_en, ch2_en, ch1_en}), 1);

    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        panic_idle();
      end else if (r < 25 && m_en != '0) begin
        do v = int'($urandom_range(0, 3)); while (!m_en[v]);
        send(1'b0, m_note[v]);
      end else begin
        send(1'(r < 75), int'($urandom_range(34, 98)));
      end
    end

    repeat (5) @(negedge clk);
    chk_val("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
